arbiter_responder: RTL
======================

Name: arbiter_responder

Overview:
- Target-side endpoint for the root of an arbiter_cascade tree. It sits on the root's req_out / ack_out / sel pins.
- Accepts the granted request, latches which requester won, and services it for a fixed number of cycles (stretched by stall). It then completes the four-phase handshake back into the tree.
- Also reports served grants and flags protocol violations by the arbiter side.

Parameters:
- INPUT_SIZE, 2, number of requesters; width of the one-hot sel vector.
- SERVICE_CYCLES, 2, cycles from request capture to ack assertion when no stall; legal range >= 1.
- CNT_W, 8, width of the saturating grant counter.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-low reset.
- req_in  input  1  request from the arbiter root (its req_out).
- ack_out  output  1  acknowledge to the arbiter root (its ack_out).
- sel_in  input  INPUT_SIZE  one-hot winner index from the arbiter root (its sel).
- stall  input  1  downstream resource busy; freezes service countdown.
- served_valid  output  1  one-cycle pulse when a grant completes (coincides with ack_out rising).
- served_sel  output  INPUT_SIZE  sel value captured for the current/last grant.
- grant_cnt  output  CNT_W  number of acks issued since reset; saturates at all-ones.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE. ack_out=0, served_valid=0, served_sel=0, grant_cnt=0, proto_err=0, service counter=0. Reset wins over every other event, including mid-service or mid-ack; ack_out is low after that edge.
- All outputs are registered; no combinational path from input to output.
- FSM states: IDLE, SERVE, ACK.
- IDLE:
  - req_in=1 -> SERVE. served_sel<=sel_in; counter<=SERVICE_CYCLES-1.
  - If sel_in is not exactly one-hot at capture (zero or multi-bit), proto_err<=1. Service still proceeds normally with the captured value.
- SERVE:
  - req_in=0 (abort) -> IDLE, proto_err<=1, no ack, counter unchanged.
  - Else if sel_in != served_sel -> proto_err<=1; continue serving.
  - stall=1: hold state and counter.
  - stall=0 and counter==0: -> ACK. ack_out<=1, served_valid<=1, grant_cnt<=grant_cnt+1 unless already all-ones.
  - stall=0 and counter!=0: counter<=counter-1.
  - Latency: req_in sampled high at edge k, no stall -> ack_out high after edge k+SERVICE_CYCLES. Each stalled cycle adds one.
- ACK:
  - ack_out held 1; served_valid low after its single pulse cycle.
  - req_in=0 -> IDLE, ack_out<=0.
  - sel_in change while req_in=1 -> proto_err<=1.
  - stall ignored in ACK.
- Return to IDLE takes one edge. A new req_in=1 is only sampled in IDLE, so back-to-back grants are separated by at least one ack_out=0 cycle.
- proto_err is cleared only by reset.
- grant_cnt at all-ones stays all-ones; served_valid still pulses.
- Simultaneous req_in fall and counter==0 in SERVE: the abort rule wins. No ack, proto_err set.

Decomposition:
- Shared package arbiter_pkg holds:
  - the resp_state_t enum (IDLE, SERVE, ACK);
  - a function is_onehot(logic [N-1:0]) reused by arbiter_cascade checks.
- No sub-module; the counter and FSM stay inline in one module.

Test Plan:
- Reset: hold rst=0 for 2 edges with req_in=1 -> ack_out=0, grant_cnt=0, proto_err=0, served_sel=0.
- Nominal handshake: SERVICE_CYCLES=2, sel_in=2'b01, req_in rises at edge k.
  - Expected: ack_out=1 and served_valid pulse after edge k+2, served_sel=2'b01, grant_cnt=1.
  - Then drop req_in: ack_out=0 after the next edge.
- Stall: same as nominal, plus stall=1 for 3 cycles during SERVE -> ack_out rises after edge k+5; no proto_err.
- Abort: req_in drops after 1 cycle of SERVE -> no ack_out, state IDLE, proto_err=1 until reset.
- Bad sel: capture with sel_in=2'b11 -> proto_err=1, ack still issued after SERVICE_CYCLES. Separately, changing sel_in during ACK -> proto_err=1.
- Saturation and back-to-back: CNT_W=2, 5 complete handshakes with req_in re-raised immediately after ack_out falls.
  - Expected: grant_cnt reads 1, 2, 3, 3, 3.
  - Expected: each ack is separated by at least one ack_out=0 cycle.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the arbiter cascade and its root-side responder.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } resp_state_t;

    // Callers zero-extend narrower vectors; extension does not change one-hotness.
    localparam int SEL_MAX_W = 32;

    function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - SEL_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/arbiter_responder.sv
// Target-side endpoint for the arbiter tree root: captures the winner, services it
// for a fixed (stall-stretched) time, completes the four-phase handshake, counts grants.
module arbiter_responder
    import arbiter_pkg::*;
#(
    parameter int INPUT_SIZE     = 2,
    parameter int SERVICE_CYCLES = 2,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_in,
    output logic                  ack_out,
    input  logic [INPUT_SIZE-1:0] sel_in,
    input  logic                  stall,
    output logic                  served_valid,
    output logic [INPUT_SIZE-1:0] served_sel,
    output logic [CNT_W-1:0]      grant_cnt,
    output logic                  proto_err
);

    localparam int SVC_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;

    resp_state_t            state_q, state_d;
    logic [SVC_W-1:0]       svc_q, svc_d;
    logic                   ack_q, ack_d;
    logic                   sv_q, sv_d;
    logic [INPUT_SIZE-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]       gcnt_q, gcnt_d;
    logic                   err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            svc_q   <= '0;
            ack_q   <= 1'b0;
            sv_q    <= 1'b0;
            sel_q   <= '0;
            gcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            svc_q   <= svc_d;
            ack_q   <= ack_d;
            sv_q    <= sv_d;
            sel_q   <= sel_d;
            gcnt_q  <= gcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        svc_d   = svc_q;
        ack_d   = ack_q;
        sv_d    = 1'b0;
        sel_d   = sel_q;
        gcnt_d  = gcnt_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_in) begin
                    state_d = SERVE;
                    sel_d   = sel_in;
                    svc_d   = SVC_W'(SERVICE_CYCLES - 1);
                    if (!is_onehot(SEL_MAX_W'(sel_in))) begin
                        err_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                // A dropped request beats a countdown that expires on the same edge.
                if (!req_in) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    if (sel_in != sel_q) begin
                        err_d = 1'b1;
                    end
                    if (!stall) begin
                        if (svc_q == '0) begin
                            state_d = ACK;
                            ack_d   = 1'b1;
                            sv_d    = 1'b1;
                            if (gcnt_q != '1) begin
                                gcnt_d = gcnt_q + CNT_W'(1);
                            end
                        end else begin
                            svc_d = svc_q - SVC_W'(1);
                        end
                    end
                end
            end
            ACK: begin
                if (!req_in) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end else if (sel_in != sel_q) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    assign ack_out      = ack_q;
    assign served_valid = sv_q;
    assign served_sel   = sel_q;
    assign grant_cnt    = gcnt_q;
    assign proto_err    = err_q;

endmodule
